// File: rtl/neosd_dat_rx.sv
// SD DAT-line block receiver: start bit, BLOCK_LEN payload bytes, per-line CRC16, end bit.
// Define NEOSD_DAT_RX_4BIT_EN to add the 4-bit bus mode; otherwise only DAT0 is used.
module neosd_dat_rx #(
  parameter int BLOCK_LEN = 512,
  parameter int TIMEOUT   = 65535
) (
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic       clkstrb_i,
  input  logic       start_i,
  input  logic       abort_i,
  input  logic       bus4_i,
  input  logic [3:0] sd_dat_i,
  output logic [7:0] data_o,
  output logic       valid_o,
  output logic       busy_o,
  output logic       done_o,
  output logic       crc_err_o,
  output logic       end_err_o,
  output logic       timeout_o,
  output logic [2:0] dbg_state_o
);

  typedef enum logic [2:0] {S_IDLE, S_WAIT_START, S_DATA, S_CRC, S_END} state_t;

  localparam int BC_W = $clog2(BLOCK_LEN + 1);
  localparam int TC_W = $clog2(TIMEOUT + 1);

`ifdef NEOSD_DAT_RX_4BIT_EN
  localparam int NLINES = 4;
  logic       r_bus4;
  logic       w_bus4;
  logic [3:0] w_dat;
  assign w_bus4 = r_bus4;
  assign w_dat  = sd_dat_i;
`else
  localparam int NLINES = 1;
  logic       w_bus4;
  logic [3:0] w_dat;
  logic       w_unused;
  assign w_bus4   = 1'b0;
  assign w_dat    = {3'b000, sd_dat_i[0]};
  assign w_unused = &{1'b0, bus4_i, sd_dat_i[3:1]};
`endif

  state_t            r_state, w_next;
  logic [BC_W-1:0]   r_byte_cnt;
  logic [2:0]        r_bit_cnt;
  logic [TC_W-1:0]   r_tmo_cnt;
  logic [3:0]        r_crc_cnt;
  logic [7:0]        r_shift;
  logic [15:0]       r_crc [NLINES];
  logic [7:0]        r_data;
  logic              r_valid, r_done, r_crc_err, r_end_err, r_timeout;

  logic       w_start_bit, w_end_ok, w_byte_done, w_last_byte, w_tmo_hit;
  logic [7:0] w_byte;

  assign w_start_bit = w_bus4 ? (w_dat == 4'h0) : ~w_dat[0];
  assign w_end_ok    = w_bus4 ? (w_dat == 4'hF) : w_dat[0];
  assign w_byte_done = w_bus4 ? r_bit_cnt[0] : (r_bit_cnt == 3'd7);
  assign w_last_byte = (r_byte_cnt == BC_W'(BLOCK_LEN - 1));
  assign w_tmo_hit   = (r_tmo_cnt >= TC_W'(TIMEOUT - 1));
  // Nibble mode shifts four lines at once, DAT3 landing in the MSB position.
  assign w_byte      = w_bus4 ? {r_shift[3:0], w_dat} : {r_shift[6:0], w_dat[0]};

  function automatic logic [15:0] crc16_step(input logic [15:0] c, input logic b);
    logic fb;
    fb = b ^ c[15];
    return {c[14:0], 1'b0} ^ (fb ? 16'h1021 : 16'h0000);
  endfunction

  always_ff @(posedge clk_i) begin
    if (rst_i) r_state <= S_IDLE;
    else       r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    if (abort_i) begin
      w_next = S_IDLE;
    end else begin
      case (r_state)
        S_IDLE:       if (start_i) w_next = S_WAIT_START;
        S_WAIT_START: if (clkstrb_i) begin
                        if (w_start_bit)    w_next = S_DATA;
                        else if (w_tmo_hit) w_next = S_IDLE;
                      end
        S_DATA:       if (clkstrb_i && w_byte_done && w_last_byte) w_next = S_CRC;
        S_CRC:        if (clkstrb_i && (r_crc_cnt == 4'hF)) w_next = S_END;
        S_END:        if (clkstrb_i) w_next = S_IDLE;
        default:      w_next = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
`ifdef NEOSD_DAT_RX_4BIT_EN
      r_bus4 <= 1'b0;
`endif
      r_byte_cnt <= '0;
      r_bit_cnt  <= '0;
      r_tmo_cnt  <= '0;
      r_crc_cnt  <= '0;
      r_shift    <= '0;
      for (int i = 0; i < NLINES; i++) r_crc[i] <= '0;
      r_data     <= '0;
      r_valid    <= 1'b0;
      r_done     <= 1'b0;
      r_crc_err  <= 1'b0;
      r_end_err  <= 1'b0;
      r_timeout  <= 1'b0;
    end else begin
      r_valid <= 1'b0;
      r_done  <= 1'b0;
      // Abort leaves flags and datapath as they are; the next start clears them.
      if (!abort_i) begin
        case (r_state)
          S_IDLE: if (start_i) begin
`ifdef NEOSD_DAT_RX_4BIT_EN
            r_bus4 <= bus4_i;
`endif
            r_byte_cnt <= '0;
            r_bit_cnt  <= '0;
            r_tmo_cnt  <= '0;
            r_crc_cnt  <= '0;
            for (int i = 0; i < NLINES; i++) r_crc[i] <= '0;
            r_crc_err  <= 1'b0;
            r_end_err  <= 1'b0;
            r_timeout  <= 1'b0;
          end
          S_WAIT_START: if (clkstrb_i && !w_start_bit) begin
            if (r_tmo_cnt != TC_W'(TIMEOUT)) r_tmo_cnt <= r_tmo_cnt + TC_W'(1);
            if (w_tmo_hit) begin
              r_timeout <= 1'b1;
              r_done    <= 1'b1;
            end
          end
          S_DATA: if (clkstrb_i) begin
            r_shift <= w_byte;
            for (int i = 0; i < NLINES; i++)
              if ((i == 0) || w_bus4) r_crc[i] <= crc16_step(r_crc[i], w_dat[i]);
            if (w_byte_done) begin
              r_bit_cnt  <= '0;
              r_byte_cnt <= r_byte_cnt + BC_W'(1);
              r_data     <= w_byte;
              r_valid    <= 1'b1;
            end else begin
              r_bit_cnt <= r_bit_cnt + 3'd1;
            end
          end
          S_CRC: if (clkstrb_i) begin
            r_crc_cnt <= r_crc_cnt + 4'd1;
            for (int i = 0; i < NLINES; i++) begin
              if (((i == 0) || w_bus4) && (w_dat[i] != r_crc[i][15])) r_crc_err <= 1'b1;
              r_crc[i] <= {r_crc[i][14:0], 1'b0};
            end
          end
          S_END: if (clkstrb_i) begin
            if (!w_end_ok) r_end_err <= 1'b1;
            r_done <= 1'b1;
          end
          default: ;
        endcase
      end
    end
  end

  assign data_o      = r_data;
  assign valid_o     = r_valid;
  assign busy_o      = (r_state != S_IDLE);
  assign done_o      = r_done;
  assign crc_err_o   = r_crc_err;
  assign end_err_o   = r_end_err;
  assign timeout_o   = r_timeout;
  assign dbg_state_o = r_state;

endmodule

// File: tb/tb_neosd_dat_rx.sv
// Scoreboard bench for neosd_dat_rx: directed blocks, CRC errors, end-bit errors, timeout, abort, reset.
module tb_neosd_dat_rx;
  localparam int BL  = 512;
  localparam int TMO = 8;

  logic       clk = 1'b0;
  logic       rst_i = 1'b1, clkstrb_i = 1'b0, start_i = 1'b0, abort_i = 1'b0, bus4_i = 1'b0;
  logic [3:0] sd_dat_i = 4'hF;
  logic [7:0] data_o;
  logic       valid_o, busy_o, done_o, crc_err_o, end_err_o, timeout_o;
  logic [2:0] dbg_state_o;

  always #5 clk = ~clk;

  neosd_dat_rx #(.BLOCK_LEN(BL), .TIMEOUT(TMO)) dut (
    .clk_i(clk), .rst_i(rst_i), .clkstrb_i(clkstrb_i), .start_i(start_i),
    .abort_i(abort_i), .bus4_i(bus4_i), .sd_dat_i(sd_dat_i), .data_o(data_o),
    .valid_o(valid_o), .busy_o(busy_o), .done_o(done_o), .crc_err_o(crc_err_o),
    .end_err_o(end_err_o), .timeout_o(timeout_o), .dbg_state_o(dbg_state_o)
  );

  logic [7:0]  exp_q[$];
  logic [2:0]  exp_flag_q[$];   // {timeout, end_err, crc_err}
  int          exp_len_q[$];    // strobes from start bit (or start_i) to done
  int          total = 0, bad = 0;
  int          strb_cnt = 0, strb_mark = 0, g_gap = 0;
  logic [7:0]  blk [BL];
  logic [15:0] g_crc [4];

  always @(posedge clk) if (clkstrb_i) strb_cnt <= strb_cnt + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    end
  endtask

  // Monitor: pops expectations whenever the DUT presents a byte or a completion.
  always @(negedge clk) begin
    if (rst_i === 1'b0) begin
      if (valid_o) begin
        if (exp_q.size() == 0) begin
          total++; bad++;
          $display("FAIL unexpected_byte: got %0h want none", data_o);
        end else chk("byte", data_o, exp_q.pop_front());
      end
      if (done_o) begin
        if (exp_flag_q.size() == 0) begin
          total++; bad++;
          $display("FAIL unexpected_done: got flags %0h want no done", {timeout_o, end_err_o, crc_err_o});
        end else begin
          chk("done_flags", {timeout_o, end_err_o, crc_err_o}, exp_flag_q.pop_front());
          chk("done_strobes", strb_cnt - strb_mark, exp_len_q.pop_front());
          chk("busy_at_done", busy_o, 1'b0);
        end
      end
    end
  end

  function automatic logic [2:0] junk3();
    return 3'($urandom_range(0, 7));
  endfunction

  function automatic logic [15:0] crc_step(input logic [15:0] c, input logic b);
    logic [15:0] n;
    n = {c[14:0], 1'b0};
    if (b ^ c[15]) n = n ^ 16'h1021;
    return n;
  endfunction

  task automatic calc_crc(input logic fmt4);
    logic [3:0] nib;
    for (int l = 0; l < 4; l++) g_crc[l] = 16'h0;
    for (int b = 0; b < BL; b++) begin
      if (fmt4) begin
        for (int h = 0; h < 2; h++) begin
          nib = (h == 0) ? blk[b][7:4] : blk[b][3:0];
          for (int l = 0; l < 4; l++) g_crc[l] = crc_step(g_crc[l], nib[l]);
        end
      end else begin
        for (int k = 7; k >= 0; k--) g_crc[0] = crc_step(g_crc[0], blk[b][k]);
      end
    end
  endtask

  task automatic fill(input int mul, input int add);
    for (int i = 0; i < BL; i++) blk[i] = 8'((i * mul + add) & 255);
  endtask

  task automatic strobe(input logic [3:0] d);
    repeat (g_gap) begin @(negedge clk); clkstrb_i = 1'b0; start_i = 1'b0; end
    @(negedge clk);
    clkstrb_i = 1'b1; sd_dat_i = d; start_i = 1'b0;
  endtask

  task automatic do_start(input logic pin4);
    @(negedge clk);
    clkstrb_i = 1'b0; bus4_i = pin4; start_i = 1'b1;
    @(negedge clk);
    start_i = 1'b0;
    chk("busy_rise", busy_o, 1'b1);
  endtask

  // Drives idle-high strobes, start bit, nbytes of blk[], then (full block only) CRC and end bit.
  task automatic run_block(input logic fmt4, input int nbytes, input logic [15:0] flip,
                           input logic [3:0] endv, input logic [2:0] flags, input int len,
                           input int poke);
    logic [3:0] d;
    repeat (3) strobe(fmt4 ? 4'hF : {junk3(), 1'b1});
    strobe(fmt4 ? 4'h0 : {junk3(), 1'b0});
    strb_mark = strb_cnt;
    for (int b = 0; b < nbytes; b++) begin
      if (fmt4) begin
        strobe(blk[b][7:4]);
        strobe(blk[b][3:0]);
      end else begin
        for (int k = 7; k >= 0; k--) strobe({junk3(), blk[b][k]});
      end
      exp_q.push_back(blk[b]);
      if (b == poke) begin start_i = 1'b1; bus4_i = 1'b1; end
    end
    if (nbytes < BL) return;
    for (int k = 15; k >= 0; k--) begin
      if (fmt4) d = {g_crc[3][k], g_crc[2][k], g_crc[1][k], g_crc[0][k] ^ flip[k]};
      else      d = {junk3(), g_crc[0][k] ^ flip[k]};
      strobe(d);
    end
    exp_flag_q.push_back(flags);
    exp_len_q.push_back(len);
    strobe(fmt4 ? endv : {junk3(), endv[0]});
    @(negedge clk);
    clkstrb_i = 1'b0;
  endtask

  task automatic drain(input string name);
    for (int i = 0; i < 100 && (exp_q.size() != 0 || exp_flag_q.size() != 0); i++) @(negedge clk);
    chk(name, exp_q.size() + exp_flag_q.size(), 0);
  endtask

  initial begin
    repeat (3) @(negedge clk);
    chk("reset_outputs", {data_o, valid_o, busy_o, done_o, crc_err_o, end_err_o, timeout_o}, 0);
    rst_i = 1'b0;

    // 1-bit, 512 x 0xFF, known CRC 0x7FA1
    for (int i = 0; i < BL; i++) blk[i] = 8'hFF;
    g_crc[0] = 16'h7FA1; g_crc[1] = 16'h0; g_crc[2] = 16'h0; g_crc[3] = 16'h0;
    do_start(1'b0);
    run_block(1'b0, BL, 16'h0000, 4'hF, 3'b000, 8 * BL + 18, -1);
    drain("ff_block_drain");

    // Same block with CRC bit 0 flipped
    do_start(1'b0);
    run_block(1'b0, BL, 16'h0001, 4'hF, 3'b001, 8 * BL + 18, -1);
    drain("bad_crc_drain");
    repeat (3) @(negedge clk);
    chk("crc_err_held", crc_err_o, 1'b1);

`ifdef NEOSD_DAT_RX_4BIT_EN
    // 4-bit, all zero, all CRCs zero
    for (int i = 0; i < BL; i++) blk[i] = 8'h00;
    for (int l = 0; l < 4; l++) g_crc[l] = 16'h0;
    do_start(1'b1);
    run_block(1'b1, BL, 16'h0000, 4'hF, 3'b000, 2 * BL + 18, -1);
    drain("zero4_drain");
    // 4-bit, DAT2 low on the end bit
    fill(13, 7);
    calc_crc(1'b1);
    do_start(1'b1);
    run_block(1'b1, BL, 16'h0000, 4'b1011, 3'b010, 2 * BL + 18, -1);
    drain("end4_drain");
`else
    // bus4_i is ignored without 4-bit support: framing stays 1-bit
    fill(13, 7);
    calc_crc(1'b0);
    do_start(1'b1);
    run_block(1'b0, BL, 16'h0000, 4'h1, 3'b000, 8 * BL + 18, -1);
    drain("bus4_ignored_drain");
    do_start(1'b0);
    run_block(1'b0, BL, 16'h0000, 4'h0, 3'b010, 8 * BL + 18, -1);
    drain("end1_drain");
`endif

    // Start-bit timeout
    do_start(1'b0);
    strb_mark = strb_cnt;
    exp_flag_q.push_back(3'b100);
    exp_len_q.push_back(TMO);
    repeat (TMO + 4) strobe(4'hF);
    @(negedge clk); clkstrb_i = 1'b0;
    drain("timeout_drain");

    // start_i with abort_i in IDLE: stays idle, flags untouched
    @(negedge clk); start_i = 1'b1; abort_i = 1'b1;
    @(negedge clk); start_i = 1'b0; abort_i = 1'b0;
    chk("start_abort_idle_busy", busy_o, 1'b0);
    chk("start_abort_idle_flags", {timeout_o, end_err_o, crc_err_o}, 3'b100);

    // Abort after 100 bytes
    fill(29, 3);
    do_start(1'b0);
    run_block(1'b0, 100, 16'h0000, 4'hF, 3'b000, 0, -1);
    @(negedge clk); clkstrb_i = 1'b0; abort_i = 1'b1;
    @(negedge clk); abort_i = 1'b0;
    chk("abort_busy", busy_o, 1'b0);
    repeat (20) @(negedge clk);
    drain("abort_drain");

    // Clean block after abort, half-rate strobes, stray start_i mid-block
    g_gap = 1;
    fill(37, 5);
    calc_crc(1'b0);
    do_start(1'b0);
    run_block(1'b0, BL, 16'h0000, 4'hF, 3'b000, 8 * BL + 18, 200);
    drain("restart_drain");
    g_gap = 0;
    bus4_i = 1'b0;

    // Reset mid-block
    do_start(1'b0);
    run_block(1'b0, 10, 16'h0000, 4'hF, 3'b000, 0, -1);
    @(negedge clk); clkstrb_i = 1'b0;
    @(negedge clk); rst_i = 1'b1;
    @(negedge clk);
    chk("reset_mid_block", {data_o, valid_o, busy_o, done_o, crc_err_o, end_err_o, timeout_o}, 0);
    rst_i = 1'b0;
    repeat (5) @(negedge clk);
    drain("final_drain");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
